// File: rtl/benes_cfg_ctrl_pkg.sv
// Purpose: shared sizes, vector types and FSM encoding for the Benes configuration controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package benes_cfg_ctrl_pkg;

  localparam int SIZE        = 16;
  localparam int LOG2_SIZE   = $clog2(SIZE);
  localparam int STAGE_NUM   = 2*LOG2_SIZE-1;
  localparam int SW_W        = SIZE/2;
  localparam int DATA_W      = 4;
  localparam int STAGE_LAT   = 2;
  localparam int NET_LAT     = 13;
  localparam int DRAIN_CYC   = STAGE_LAT*(STAGE_NUM-1);
  localparam int CFG_STAGE_W = $clog2(STAGE_NUM+1);

  typedef logic [SIZE-1:0][DATA_W-1:0]    port_vec_t;
  typedef logic [STAGE_NUM-1:0][SW_W-1:0] sw_set_t;

  typedef enum logic [1:0] {
    NO_CFG = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/benes_cfg_skew.sv
// Purpose: per-stage bank-select delay line; tap k is the active bank index delayed STAGE_LAT*k cycles.
// Latency: tap 0 is combinational, tap k lags by STAGE_LAT*k cycles.
// Backpressure: none, shifts every cycle.
// Ports: clk/rst (sync, active-high), i_active (current active bank), o_sel (one select bit per stage).
module benes_cfg_skew #(
  parameter int STAGE_NUM = benes_cfg_ctrl_pkg::STAGE_NUM,
  parameter int STAGE_LAT = benes_cfg_ctrl_pkg::STAGE_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_active,
  output logic [STAGE_NUM-1:0] o_sel
);

  localparam int DEPTH = STAGE_LAT*(STAGE_NUM-1);

  // r_sr[n] holds the active index as it was n cycles ago.
  logic [DEPTH:1] r_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[DEPTH-1:1], i_active};
    end
  end

  always_comb begin
    o_sel    = '0;
    o_sel[0] = i_active;
    for (int k = 1; k < STAGE_NUM; k++) begin
      o_sel[k] = r_sr[STAGE_LAT*k];
    end
  end

endmodule

// File: rtl/benes_cfg_ctrl.sv
// Purpose: double-banked switch configuration for a pipelined Benes network, with hitless bank swap.
// Latency: in handshake -> network input 1 cycle; in handshake -> out_valid/out_data NET_LAT+1 cycles.
// Backpressure: in_ready low until first commit; cfg_ready low while a swap drains; output has none.
// Ports: cfg_* load shadow bank / commit, in_* data in, net_* drive/receive the network, out_* result.
module benes_cfg_ctrl #(
  parameter int SIZE      = benes_cfg_ctrl_pkg::SIZE,
  parameter int STAGE_NUM = 2*$clog2(SIZE)-1,
  parameter int SW_W      = SIZE/2,
  parameter int DATA_W    = benes_cfg_ctrl_pkg::DATA_W,
  parameter int STAGE_LAT = benes_cfg_ctrl_pkg::STAGE_LAT,
  parameter int NET_LAT   = benes_cfg_ctrl_pkg::NET_LAT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [benes_cfg_ctrl_pkg::CFG_STAGE_W-1:0]  cfg_stage,
  input  logic [SW_W-1:0]                             cfg_bits,
  input  logic                                        cfg_commit,
  output logic                                        cfg_err,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [SIZE-1:0][DATA_W-1:0]                 in_data,
  output logic [SIZE-1:0][DATA_W-1:0]                 net_i_port,
  output logic [STAGE_NUM-1:0][SW_W-1:0]              net_switch_set,
  input  logic [SIZE-1:0][DATA_W-1:0]                 net_o_port,
  output logic                                        out_valid,
  output logic [SIZE-1:0][DATA_W-1:0]                 out_data
);

  import benes_cfg_ctrl_pkg::*;

  localparam int DRAIN_LEN = STAGE_LAT*(STAGE_NUM-1);
  localparam int DRAIN_W   = $clog2(DRAIN_LEN);

  // Configuration state
  logic [1:0][STAGE_NUM-1:0][SW_W-1:0] r_bank;
  logic [STAGE_NUM-1:0]                r_mask;
  logic                                r_active;
  logic                                r_cfg_err;

  // FSM
  state_t             r_state, w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt, w_drain_cnt_nxt;

  // Datapath
  logic [SIZE-1:0][DATA_W-1:0] r_net_i;
  logic [SIZE-1:0][DATA_W-1:0] r_out_data;
  logic [NET_LAT:0]            r_vld_sr;
  logic                        r_out_valid;

  logic                 w_cfg_hs;
  logic                 w_in_hs;
  logic                 w_stage_ok;
  logic [STAGE_NUM-1:0] w_stage_bit;
  logic [STAGE_NUM-1:0] w_mask_nxt;
  logic                 w_commit_ok;
  logic                 w_err;
  logic [STAGE_NUM-1:0] w_sel;

  assign cfg_ready = (r_state != DRAIN);
  assign in_ready  = (r_state != NO_CFG);
  assign w_cfg_hs  = cfg_valid && cfg_ready;
  assign w_in_hs   = in_valid && in_ready;

  // The commit sees the mask including a write made on the same handshake.
  assign w_stage_ok  = int'(cfg_stage) < STAGE_NUM;
  assign w_stage_bit = w_stage_ok ? (STAGE_NUM'(1) << cfg_stage) : '0;
  assign w_mask_nxt  = r_mask | w_stage_bit;
  assign w_commit_ok = w_cfg_hs && cfg_commit && (&w_mask_nxt);
  assign w_err       = w_cfg_hs && (!w_stage_ok || (cfg_commit && !(&w_mask_nxt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank    <= '0;
      r_mask    <= '0;
      r_active  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_err;
      if (w_cfg_hs && w_stage_ok) begin
        r_bank[~r_active][cfg_stage] <= cfg_bits;
      end
      if (w_commit_ok) begin
        r_active <= ~r_active;
        r_mask   <= '0;
      end else if (w_cfg_hs) begin
        r_mask   <= w_mask_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= NO_CFG;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // DRAIN blocks config writes until the last stage's select has moved to the
  // new bank, so the old bank (now shadow) is not touched while still in use.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      NO_CFG, RUN: begin
        if (w_commit_ok) begin
          w_state_nxt     = DRAIN;
          w_drain_cnt_nxt = DRAIN_W'(DRAIN_LEN-1);
        end
      end
      DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = NO_CFG;
      end
    endcase
  end

  benes_cfg_skew #(
    .STAGE_NUM (STAGE_NUM),
    .STAGE_LAT (STAGE_LAT)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .i_active (r_active),
    .o_sel    (w_sel)
  );

  // Each stage reads the bank that was active when the word now at that stage entered.
  always_comb begin
    net_switch_set = '0;
    for (int k = 0; k < STAGE_NUM; k++) begin
      net_switch_set[k] = r_bank[w_sel[k]][k];
    end
  end

  // r_vld_sr[0] marks a word at the network input, r_vld_sr[NET_LAT] one at its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_net_i     <= '0;
      r_vld_sr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_in_hs) begin
        r_net_i <= in_data;
      end
      r_vld_sr    <= {r_vld_sr[NET_LAT-1:0], w_in_hs};
      r_out_valid <= r_vld_sr[NET_LAT];
      r_out_data  <= net_o_port;
    end
  end

  assign net_i_port = r_net_i;
  assign cfg_err    = r_cfg_err;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
module tb_benes_cfg_ctrl;
  import benes_cfg_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CFG_STAGE_W-1:0] cfg_stage;
  logic [SW_W-1:0]        cfg_bits;
  logic                   cfg_commit;
  logic                   cfg_err;
  logic                   in_valid;
  logic                   in_ready;
  port_vec_t              in_data;
  port_vec_t              net_i_port;
  sw_set_t                net_switch_set;
  port_vec_t              net_o_port;
  logic                   out_valid;
  port_vec_t              out_data;

  always #5 clk = ~clk;

  benes_cfg_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_stage      (cfg_stage),
    .cfg_bits       (cfg_bits),
    .cfg_commit     (cfg_commit),
    .cfg_err        (cfg_err),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .net_i_port     (net_i_port),
    .net_switch_set (net_switch_set),
    .net_o_port     (net_o_port),
    .out_valid      (out_valid),
    .out_data       (out_data)
  );

  // One Benes stage: stages 0..3 pair ports differing in bit 3,2,1,0; stages 4..6 in bit 1,2,3.
  function automatic port_vec_t sw_stage(port_vec_t d, logic [SW_W-1:0] set, int s);
    port_vec_t r;
    int b;
    r = d;
    b = (s < LOG2_SIZE) ? (LOG2_SIZE-1-s) : (s-LOG2_SIZE+1);
    for (int j = 0; j < SW_W; j++) begin
      int lo;
      int hi;
      lo = ((j >> b) << (b+1)) | (j & ((1 << b) - 1));
      hi = lo | (1 << b);
      if (set[j]) begin
        r[lo] = d[hi];
        r[hi] = d[lo];
      end
    end
    return r;
  endfunction

  // External pipelined network: each stage applies the switch setting present
  // while the word sits at its input, then takes STAGE_LAT cycles to the next.
  port_vec_t em_a [STAGE_NUM]   = '{default: '0};
  port_vec_t em_b [STAGE_NUM-1] = '{default: '0};

  always @(posedge clk) begin
    em_a[0] <= sw_stage(net_i_port, net_switch_set[0], 0);
    for (int k = 1; k < STAGE_NUM; k++) begin
      em_a[k] <= sw_stage(em_b[k-1], net_switch_set[k], k);
    end
    for (int k = 0; k < STAGE_NUM-1; k++) begin
      em_b[k] <= em_a[k];
    end
  end
  assign net_o_port = em_a[STAGE_NUM-1];

  // Reference model, kept at transaction level.
  localparam int M_NONE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  typedef struct {
    port_vec_t dat;
    int        due;
  } exp_t;

  int               m_state;
  int               m_left;
  bit               m_active;
  logic [SW_W-1:0]  m_bank [2][STAGE_NUM];
  logic [STAGE_NUM-1:0] m_mask;
  bit               m_err_exp;
  exp_t             sb [$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_err  = 0;
  int n_out  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic port_vec_t benes_ref(port_vec_t d, bit bank);
    port_vec_t r;
    r = d;
    for (int s = 0; s < STAGE_NUM; s++) begin
      r = sw_stage(r, m_bank[bank][s], s);
    end
    return r;
  endfunction

  // Applies one clock edge's worth of inputs to the model (called before the edge).
  task automatic model_edge();
    bit in_rdy;
    bit cfg_rdy;
    bit commit_ok;
    exp_t e;
    in_rdy    = (m_state != M_NONE);
    cfg_rdy   = (m_state != M_DRAIN);
    m_err_exp = 1'b0;
    commit_ok = 1'b0;
    if (rst) begin
      m_state  = M_NONE;
      m_left   = 0;
      m_active = 1'b0;
      m_mask   = '0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < STAGE_NUM; s++)
          m_bank[b][s] = '0;
      sb.delete();
      return;
    end
    if (cfg_valid && cfg_rdy) begin
      if (int'(cfg_stage) < STAGE_NUM) begin
        m_bank[!m_active][cfg_stage] = cfg_bits;
        m_mask[cfg_stage] = 1'b1;
      end else begin
        m_err_exp = 1'b1;
      end
      if (cfg_commit) begin
        if (m_mask == {STAGE_NUM{1'b1}}) commit_ok = 1'b1;
        else m_err_exp = 1'b1;
      end
    end
    if (m_state == M_DRAIN) begin
      m_left--;
      if (m_left == 0) m_state = M_RUN;
    end
    if (commit_ok) begin
      m_active = !m_active;
      m_mask   = '0;
      m_state  = M_DRAIN;
      m_left   = DRAIN_CYC;
    end
    if (in_valid && in_rdy) begin
      e.dat = benes_ref(in_data, m_active);
      e.due = cyc + 1 + NET_LAT + 1;
      sb.push_back(e);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("out_valid_unexpected", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        n_out++;
        chk("out_latency", 64'(cyc), 64'(e.due));
        chk("out_data", out_data, e.dat);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("out_valid_missing", 64'(out_valid), 64'(1));
      void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    chk("in_ready", 64'(in_ready), 64'(m_state != M_NONE));
    chk("cfg_ready", 64'(cfg_ready), 64'(m_state != M_DRAIN));
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    chk("cfg_err", 64'(cfg_err), 64'(m_err_exp));
    check_out();
  endtask

  task automatic cfg_write(int stage, logic [SW_W-1:0] bits, bit commit);
    cfg_valid  = 1'b1;
    cfg_stage  = CFG_STAGE_W'(stage);
    cfg_bits   = bits;
    cfg_commit = commit;
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  port_vec_t ident;
  int        n_lo;
  int        n0;
  int        n_ov;

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_stage  = '0;
    cfg_bits   = '0;
    cfg_commit = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    m_state    = M_NONE;
    m_left     = 0;
    m_active   = 1'b0;
    m_mask     = '0;
    for (int p = 0; p < SIZE; p++) ident[p] = DATA_W'(p);
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("rst_cfg_err", 64'(cfg_err), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_switch_set", 64'(net_switch_set), 64'(0));
    chk("rst_net_i", net_i_port, 64'(0));
    chk("rst_out_data", out_data, 64'(0));

    // Out-of-range stage
    cfg_write(7, 8'hA5, 1'b0);
    chk("stage7_err", 64'(cfg_err), 64'(1));
    tick();
    chk("stage7_err_pulse_end", 64'(cfg_err), 64'(0));

    // Incomplete shadow bank commit is rejected
    for (int s = 0; s < 6; s++) cfg_write(s, 8'h00, 1'b0);
    cfg_write(0, 8'h00, 1'b1);
    chk("partial_commit_err", 64'(cfg_err), 64'(1));
    cfg_write(7, 8'h3C, 1'b1);
    repeat (3) tick();
    chk("partial_in_ready", 64'(in_ready), 64'(0));

    // Full load + commit, identity data through drain
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(s, 8'h00, s == STAGE_NUM-1);
    chk("commit_no_err", 64'(cfg_err), 64'(0));
    chk("commit_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = ident;
    n_lo     = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cfg_ready) n_lo++;
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        chk("ident_latency", 64'(i), 64'(NET_LAT+1));
        chk("ident_data", out_data, ident);
      end
    end
    chk("drain_len", 64'(n_lo), 64'(DRAIN_CYC));

    // Bank A all-cross, then stream 30 words while loading bank B (straight) and committing mid-stream
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(s, 8'hFF, s == STAGE_NUM-1);
    repeat (DRAIN_CYC + 1) tick();
    n0 = n_out;
    for (int i = 0; i < 30; i++) begin
      in_valid   = 1'b1;
      in_data    = {$urandom, $urandom};
      cfg_valid  = (i >= 4 && i <= 10);
      cfg_stage  = CFG_STAGE_W'(i - 4);
      cfg_bits   = 8'h00;
      cfg_commit = (i == 10);
      tick();
    end
    in_valid   = 1'b0;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    repeat (20) tick();
    chk("stream_count", 64'(n_out - n0), 64'(30));

    // Random traffic and configuration
    for (int i = 0; i < 600; i++) begin
      in_valid   = $urandom_range(1, 0) == 1;
      in_data    = {$urandom, $urandom};
      cfg_valid  = $urandom_range(2, 0) == 0;
      cfg_stage  = CFG_STAGE_W'($urandom_range(7, 0));
      cfg_bits   = SW_W'($urandom);
      cfg_commit = $urandom_range(5, 0) == 0;
      tick();
    end
    in_valid   = 1'b0;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    repeat (20) tick();

    // Reset during DRAIN with words in flight
    for (int i = 0; i < 20 && m_state != M_RUN; i++) tick();
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(s, SW_W'($urandom), s == STAGE_NUM-1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_ov = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
      if (out_valid) n_ov++;
    end
    in_valid = 1'b0;
    chk("rst_flight_no_out", 64'(n_ov), 64'(0));
    chk("rst_flight_in_ready", 64'(in_ready), 64'(0));
    chk("rst_flight_cfg_ready", 64'(cfg_ready), 64'(1));
    chk("rst_flight_switch_set", 64'(net_switch_set), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/benes_cfg_ctrl.md
BENES_CFG_CTRL -- requirements
Module: benes_cfg_ctrl

Interface
REQ-001 SHALL have parameters: SIZE, 16, port count; STAGE_NUM, 2*clog2(SIZE)-1 (=7), switch stages; SW_W, SIZE/2 (=8), switch bits per stage; DATA_W, 4, port data width; STAGE_LAT, 2, cycles between successive stage inputs; NET_LAT, 13, network input-to-output latency.
REQ-002 SHALL have ports: clk  in  1  the single clock, all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 cfg_valid  in  1  configuration word offered.
REQ-005 cfg_ready  out  1  configuration word accepted when both high.
REQ-006 cfg_stage  in  3  target stage index, 0..STAGE_NUM-1.
REQ-007 cfg_bits  in  SW_W  switch settings for that stage.
REQ-008 cfg_commit  in  1  request to make the shadow bank active; sampled only on a cfg handshake.
REQ-009 cfg_err  out  1  one-cycle pulse on a rejected commit or an out-of-range stage.
REQ-010 in_valid / in_ready  in / out  1 / 1  input data handshake.
REQ-011 in_data  in  SIZE x DATA_W  one word per port.
REQ-012 net_i_port  out  SIZE x DATA_W  drives network inputs.
REQ-013 net_switch_set  out  STAGE_NUM x SW_W  drives network switch controls.
REQ-014 net_o_port  in  SIZE x DATA_W  network outputs.
REQ-015 out_valid / out_data  out  1 / SIZE x DATA_W  permuted result; no backpressure.

Function
REQ-016 SHALL hold two configuration banks (STAGE_NUM x SW_W each), one active and one shadow, plus a STAGE_NUM-bit loaded mask for the shadow bank.
REQ-017 On a cfg handshake with cfg_stage < STAGE_NUM: write cfg_bits to shadow[cfg_stage] and set mask bit; rewrites overwrite.
REQ-018 cfg_stage >= STAGE_NUM: no write; cfg_err pulses the next cycle.
REQ-019 Commit on the same handshake is evaluated after that cycle's write; accepted only if the mask is all ones, else ignored and cfg_err pulses.
REQ-020 On accepted commit: toggle active-bank index, clear mask, FSM to DRAIN.
REQ-021 FSM states: NO_CFG (reset; in_ready=0, cfg_ready=1); RUN (in_ready=1, cfg_ready=1); DRAIN (in_ready=1, cfg_ready=0 for exactly STAGE_LAT*(STAGE_NUM-1)=12 cycles, then RUN).
REQ-022 NO_CFG -> DRAIN on first accepted commit; no other transitions.
REQ-023 Per-stage bank select sel[k] SHALL equal the active index delayed STAGE_LAT*k cycles; net_switch_set[k] = bank[sel[k]][k], combinational from registered state.
REQ-024 Consequence: every data word is switched entirely by the configuration active in its input cycle, including words in flight across a commit.
REQ-025 net_i_port = in_data registered when in_valid && in_ready, else holds the previous value; data enters the network one cycle after the handshake.
REQ-026 out_valid SHALL be in-handshake delayed NET_LAT+1 cycles via a shift register; out_data = net_o_port registered alongside; out_valid is never asserted for unaccepted inputs.
REQ-027 Back-to-back inputs at one word per cycle SHALL be sustained in RUN and DRAIN.
REQ-028 No config handshake occurs in DRAIN, so the shadow bank is never overwritten while a delayed select still references it.

Reset
REQ-029 rst high SHALL, on the next edge: clear both banks, mask, active index and all sel[k] to 0; FSM to NO_CFG; clear the valid shift register, cfg_err, out_valid, net_i_port and out_data.
REQ-030 A reset mid-DRAIN or with data in flight SHALL discard in-flight words: no out_valid until new data is accepted after a commit.

Structure
REQ-031 A shared package SHALL hold SIZE, STAGE_NUM, SW_W, DATA_W, STAGE_LAT, NET_LAT, the port-vector and switch-set array typedefs, and the FSM state enum.
REQ-032 One sub-module, benes_cfg_skew, SHALL implement the per-stage select delay line (STAGE_NUM taps, tap k delayed STAGE_LAT*k).

Verification
REQ-033 Reset, write stages 0..6 with 8'h00, commit on the stage-6 write -> cfg_err=0, in_ready=1 the next cycle, cfg_ready=0 for 12 cycles, identity data (port i = i) returns as out_data unchanged 14 cycles after the handshake.
REQ-034 Write only stages 0..5, then commit -> cfg_err pulses, in_ready stays 0.
REQ-035 cfg_stage=7 -> cfg_err pulse, mask unchanged.
REQ-036 Stream 30 consecutive words with bank A (all 8'hFF), commit bank B (all 8'h00) mid-stream -> each word is permuted entirely by the bank active at its input cycle, with a scoreboard against a reference Benes model.
REQ-037 Assert rst during DRAIN with 5 words in flight -> no out_valid afterwards, FSM NO_CFG, net_switch_set all zero.
